usb_transmitter: RTL and testbench

Serializes one full-speed USB packet (SYNC, PID, optional CRC5 or DATA+CRC16) onto the differential d_plus/d_minus pair. It applies NRZI encoding and bit stuffing, terminates the packet with an EOP, and returns the bus to idle J. It is the transmit-side counterpart to `usb_receiver`: its packet fields match the receiver's rcv_* outputs, so a transmitter driving the receiver round-trips every field.

---
 rtl/usb_transmitter.sv | 233 +++++++++++++++++++++++
 tb/tb_usb_transmitter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_transmitter.sv
// Full-speed USB packet serializer: SYNC, PID, optional CRC5 or DATA+CRC16,
// NRZI-encoded with bit stuffing, terminated by SE0-SE0-J.
module usb_transmitter #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_start,
  input  logic [1:0]  tx_type,
  input  logic [7:0]  tx_pid,
  input  logic [4:0]  tx_crc5,
  input  logic [15:0] tx_crc16,
  input  logic [63:0] tx_data,
  output logic        d_plus,
  output logic        d_minus,
  output logic        tx_busy,
  output logic        tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SYNC    = 3'd1;
  localparam logic [2:0] ST_PID     = 3'd2;
  localparam logic [2:0] ST_CRC5    = 3'd3;
  localparam logic [2:0] ST_DATA    = 3'd4;
  localparam logic [2:0] ST_CRC16   = 3'd5;
  localparam logic [2:0] ST_EOP_SE0 = 3'd6;
  localparam logic [2:0] ST_EOP_J   = 3'd7;

  // SYNC on the wire is 0000000 then 1 (KJKJKJKK); stored here LSB first.
  localparam logic [7:0] SYNC_BITS = 8'h80;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    idx_q, idx_d;
  logic [2:0]    ones_q, ones_d;
  logic          stuff_q, stuff_d;
  logic          line_q, line_d;
  logic          dp_q, dp_d, dm_q, dm_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic [1:0]    type_q, type_d;
  logic [7:0]    pid_q, pid_d;
  logic [4:0]    crc5_q, crc5_d;
  logic [15:0]   crc16_q, crc16_d;
  logic [63:0]   data_q, data_d;

  logic          cur_bit_s, last_bit_s, nrzi_s, wrap_s;
  logic [2:0]    next_field_s;
  logic [7:0]    crc5_ext_s;

  assign crc5_ext_s = {3'b000, crc5_q};
  assign nrzi_s     = cur_bit_s ? line_q : ~line_q;
  assign wrap_s     = (cnt_q == CNT_MAX);

  // Select the current field bit, its end marker and the field that follows.
  always_comb begin
    cur_bit_s    = 1'b0;
    last_bit_s   = 1'b0;
    next_field_s = ST_EOP_SE0;
    case (state_q)
      ST_SYNC: begin
        cur_bit_s    = SYNC_BITS[idx_q[2:0]];
        last_bit_s   = (idx_q == 6'd7);
        next_field_s = ST_PID;
      end
      ST_PID: begin
        cur_bit_s  = pid_q[idx_q[2:0]];
        last_bit_s = (idx_q == 6'd7);
        if (type_q == 2'd1) begin
          next_field_s = ST_CRC5;
        end else if (type_q == 2'd2) begin
          next_field_s = ST_DATA;
        end else begin
          next_field_s = ST_EOP_SE0;
        end
      end
      ST_CRC5: begin
        cur_bit_s  = crc5_ext_s[idx_q[2:0]];
        last_bit_s = (idx_q == 6'd4);
      end
      ST_DATA: begin
        cur_bit_s    = data_q[idx_q];
        last_bit_s   = (idx_q == 6'd63);
        next_field_s = ST_CRC16;
      end
      ST_CRC16: begin
        cur_bit_s  = crc16_q[idx_q[3:0]];
        last_bit_s = (idx_q == 6'd15);
      end
      default: begin
        cur_bit_s = 1'b0;
      end
    endcase
  end

  // Next-state logic: start latch, bit launch on counter wrap, stuffing, EOP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ones_d  = ones_q;
    stuff_d = stuff_q;
    line_d  = line_q;
    dp_d    = dp_q;
    dm_d    = dm_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    type_d  = type_q;
    pid_d   = pid_q;
    crc5_d  = crc5_q;
    crc16_d = crc16_q;
    data_d  = data_q;
    if (state_q == ST_IDLE) begin
      cnt_d = CNT_ZERO;
      if (tx_start) begin
        type_d  = tx_type;
        pid_d   = tx_pid;
        crc5_d  = tx_crc5;
        crc16_d = tx_crc16;
        data_d  = tx_data;
        state_d = ST_SYNC;
        cnt_d   = CNT_MAX;
        idx_d   = 6'd0;
        ones_d  = 3'd0;
        stuff_d = 1'b0;
        line_d  = 1'b1;
        busy_d  = 1'b1;
      end else begin
        busy_d = 1'b0;
      end
    end else if (wrap_s) begin
      cnt_d = CNT_ZERO;
      if (stuff_q) begin
        // Stuffed zero: toggle without advancing the field.
        stuff_d = 1'b0;
        ones_d  = 3'd0;
        line_d  = ~line_q;
        dp_d    = ~line_q;
        dm_d    = line_q;
      end else if (state_q == ST_EOP_SE0) begin
        dp_d = 1'b0;
        dm_d = 1'b0;
        if (idx_q == 6'd1) begin
          state_d = ST_EOP_J;
          idx_d   = 6'd0;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end else if (state_q == ST_EOP_J) begin
        if (idx_q == 6'd0) begin
          dp_d   = 1'b1;
          dm_d   = 1'b0;
          line_d = 1'b1;
          idx_d  = 6'd1;
        end else begin
          state_d = ST_IDLE;
          idx_d   = 6'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end else begin
        line_d = nrzi_s;
        dp_d   = nrzi_s;
        dm_d   = ~nrzi_s;
        if (cur_bit_s) begin
          if (ones_q == 3'd5) begin
            stuff_d = 1'b1;
            ones_d  = 3'd0;
          end else begin
            ones_d = ones_q + 3'd1;
          end
        end else begin
          ones_d = 3'd0;
        end
        if (last_bit_s) begin
          state_d = next_field_s;
          idx_d   = 6'd0;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State registers with synchronous reset to idle J.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      idx_q   <= 6'd0;
      ones_q  <= 3'd0;
      stuff_q <= 1'b0;
      line_q  <= 1'b1;
      dp_q    <= 1'b1;
      dm_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      type_q  <= 2'd0;
      pid_q   <= 8'd0;
      crc5_q  <= 5'd0;
      crc16_q <= 16'd0;
      data_q  <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ones_q  <= ones_d;
      stuff_q <= stuff_d;
      line_q  <= line_d;
      dp_q    <= dp_d;
      dm_q    <= dm_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      type_q  <= type_d;
      pid_q   <= pid_d;
      crc5_q  <= crc5_d;
      crc16_q <= crc16_d;
      data_q  <= data_d;
    end
  end

  assign d_plus  = dp_q;
  assign d_minus = dm_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_usb_transmitter.sv
// Self-checking bench for usb_transmitter: a packet-level model expands each
// request into per-cycle line/busy/done expectations checked every cycle.
module tb_usb_transmitter;
  localparam int C = 8;
  localparam logic [1:0] LJ = 2'b10;
  localparam logic [1:0] LK = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;

  logic clk = 1'b0;
  logic rst, tx_start;
  logic [1:0] tx_type;
  logic [7:0] tx_pid;
  logic [4:0] tx_crc5;
  logic [15:0] tx_crc16;
  logic [63:0] tx_data;
  logic d_plus, d_minus, tx_busy, tx_done;

  usb_transmitter #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_type(tx_type),
    .tx_pid(tx_pid), .tx_crc5(tx_crc5), .tx_crc16(tx_crc16), .tx_data(tx_data),
    .d_plus(d_plus), .d_minus(d_minus), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int e0_cyc = 0;
  int done_cyc = -1;
  int done_cnt = 0;
  bit chk_en = 1'b0;
  logic [3:0] expq[$];
  logic [3:0] exp_v;
  logic [1:0] syms[$];
  int m_nbits, m_nstuff;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Packet model: raw bit list -> stuffing -> NRZI symbols -> EOP.
  task automatic build_model(input logic [1:0] typ, input logic [7:0] pid,
                             input logic [4:0] c5, input logic [15:0] c16,
                             input logic [63:0] data);
    bit b[$];
    bit s[$];
    int run;
    logic [1:0] lvl;
    for (int i = 0; i < 7; i++) b.push_back(1'b0);
    b.push_back(1'b1);
    for (int i = 0; i < 8; i++) b.push_back(pid[i]);
    if (typ == 2'd1) begin
      for (int i = 0; i < 5; i++) b.push_back(c5[i]);
    end else if (typ == 2'd2) begin
      for (int i = 0; i < 64; i++) b.push_back(data[i]);
      for (int i = 0; i < 16; i++) b.push_back(c16[i]);
    end
    run = 0;
    m_nstuff = 0;
    foreach (b[i]) begin
      s.push_back(b[i]);
      run = b[i] ? run + 1 : 0;
      if (run == 6) begin
        s.push_back(1'b0);
        m_nstuff++;
        run = 0;
      end
    end
    syms.delete();
    lvl = LJ;
    foreach (s[i]) begin
      if (!s[i]) lvl = (lvl == LJ) ? LK : LJ;
      syms.push_back(lvl);
    end
    syms.push_back(LSE0);
    syms.push_back(LSE0);
    syms.push_back(LJ);
    m_nbits = syms.size();
  endtask

  task automatic push_expect();
    expq.push_back({LJ, 1'b1, 1'b0});
    foreach (syms[i]) for (int k = 0; k < C; k++) expq.push_back({syms[i], 1'b1, 1'b0});
    expq.push_back({LJ, 1'b0, 1'b1});
  endtask

  // Per-cycle compare of {d_plus,d_minus,tx_busy,tx_done} against the model.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tx_done) begin
        done_cyc = cyc;
        done_cnt++;
      end
      if (chk_en) begin
        if (expq.size() > 0) exp_v = expq.pop_front();
        else exp_v = {LJ, 1'b0, 1'b0};
        check("dp_dm_busy_done", {d_plus, d_minus, tx_busy, tx_done}, exp_v);
      end
    end
  end

  task automatic set_in(input logic [1:0] typ, input logic [7:0] pid, input logic [4:0] c5,
                        input logic [15:0] c16, input logic [63:0] data);
    tx_type = typ; tx_pid = pid; tx_crc5 = c5; tx_crc16 = c16; tx_data = data;
  endtask

  task automatic start_pkt(input logic [1:0] typ, input logic [7:0] pid, input logic [4:0] c5,
                           input logic [15:0] c16, input logic [63:0] data);
    @(negedge clk);
    set_in(typ, pid, c5, c16, data);
    tx_start = 1'b1;
    build_model(typ, pid, c5, c16, data);
    push_expect();
    done_cyc = -1;
    @(posedge clk);
    #1;
    e0_cyc = cyc;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (expq.size() > 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: %0d expected cycles left, required 0", name, expq.size());
      expq.delete();
    end
  endtask

  // Random input churn (with tx_start pulses) while a packet is in flight.
  task automatic scramble(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      set_in(2'($urandom), 8'($urandom), 5'($urandom), 16'($urandom), {$urandom, $urandom});
      tx_start = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  initial begin
    logic [37:0] packed_syms;
    logic [63:0] rd;
    int blen, n, dc;
    rst = 1'b1;
    tx_start = 1'b0;
    set_in(2'd0, 8'd0, 5'd0, 16'd0, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_dplus", d_plus, 1'b1);
    check("reset_dminus", d_minus, 1'b0);
    check("reset_busy", tx_busy, 1'b0);
    check("reset_done", tx_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // ACK
    start_pkt(2'd0, 8'hD2, 5'd0, 16'd0, 64'd0);
    for (int i = 0; i < 19; i++) packed_syms[37-2*i -: 2] = syms[i];
    check("ack_symbols", packed_syms,
          38'b01_10_01_10_01_10_01_01_10_10_01_10_10_01_01_01_00_00_10);
    check("ack_nbits", m_nbits, 19);
    wait_idle("ack");
    check("ack_done_time", done_cyc - e0_cyc, 1 + 152);

    // Token with stuffing inside CRC5
    start_pkt(2'd1, 8'hE1, 5'h1F, 16'd0, 64'd0);
    check("token_nstuff", m_nstuff, 1);
    check("token_nbits", m_nbits, 25);
    wait_idle("token");
    check("token_done_time", done_cyc - e0_cyc, 1 + 200);

    // Stuff stress, last stuffed bit right after data bit 63
    start_pkt(2'd2, 8'hC3, 5'd0, 16'h0000, 64'hFFFF_FFFF_FFFF_FFFF);
    check("stress_nstuff", m_nstuff, 11);
    check("stress_nbits", m_nbits, 110);
    wait_idle("stress");
    check("stress_done_time", done_cyc - e0_cyc, 1 + 880);

    // Reserved type behaves as PID only
    start_pkt(2'd3, 8'h5A, 5'h1F, 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    check("type3_nbits", m_nbits, 19);
    wait_idle("type3");

    // Start requests and input churn during a packet are ignored
    start_pkt(2'd1, 8'hA5, 5'h0B, 16'd0, 64'd0);
    scramble(100);
    wait_idle("busy_ignore");

    // tx_start held through tx_done: second packet follows immediately
    @(negedge clk);
    set_in(2'd0, 8'hD2, 5'd0, 16'd0, 64'd0);
    tx_start = 1'b1;
    build_model(2'd0, 8'hD2, 5'd0, 16'd0, 64'd0);
    push_expect();
    @(posedge clk);
    #1;
    @(negedge clk);
    set_in(2'd2, 8'h4B, 5'd0, 16'hBEEF, 64'h0123_4567_89AB_CDEF);
    build_model(2'd2, 8'h4B, 5'd0, 16'hBEEF, 64'h0123_4567_89AB_CDEF);
    blen = 2 + m_nbits * C;
    push_expect();
    n = 0;
    while (expq.size() >= blen && n < 5000) begin
      @(negedge clk);
      n++;
    end
    tx_start = 1'b0;
    wait_idle("back_to_back");

    // Reset mid-DATA: lines back to J, no EOP, no done
    start_pkt(2'd2, 8'h4B, 5'd0, 16'hBEEF, {$urandom, $urandom});
    repeat (1 + 26 * C) @(negedge clk);
    rst = 1'b1;
    expq.delete();
    dc = done_cnt;
    @(posedge clk);
    #1;
    check("midrst_dplus", d_plus, 1'b1);
    check("midrst_dminus", d_minus, 1'b0);
    check("midrst_busy", tx_busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (1000) @(negedge clk);
    check("midrst_no_done", done_cnt, dc);

    // Randomized packets
    for (int p = 0; p < 20; p++) begin
      case ($urandom_range(0, 2))
        0: rd = {$urandom, $urandom};
        1: rd = 64'hFFFF_FFFF_FFFF_FFFF;
        2: rd = {$urandom, $urandom} | {$urandom, $urandom} | {$urandom, $urandom};
        default: rd = 64'd0;
      endcase
      start_pkt(2'($urandom), 8'($urandom), 5'($urandom), 16'($urandom), rd);
      scramble($urandom_range(0, 100));
      wait_idle("random_pkt");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
